// File: rtl/cls_bist_pkg.sv
// cls_bist shared definitions: FSM encoding,
// LFSR tap mask and default seed.
package cls_bist_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // x^16+x^14+x^13+x^11+1, shift-left Fibonacci:
  // feedback = q[15]^q[13]^q[12]^q[10]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] q
  );
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cls_lfsr16.sv
// 16-bit Fibonacci LFSR, advances when step=1.
// Ports: clk, rst_n (async low), step, q (state).
module cls_lfsr16
  import cls_bist_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= SEED;
    else if (step)
      q <= lfsr_next(q);
  end

endmodule

// File: rtl/cls_bist.sv
// BIST controller for a 16-bit subtractor.
// Ports: start/num_tests/ext_* in, op_* out, diff/bout in, status out.
module cls_bist
  import cls_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 8,
  parameter logic [15:0] SEED   = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  num_tests,
  input  logic        ext_en,
  input  logic [15:0] ext_a,
  input  logic [15:0] ext_b,
  input  logic        ext_bin,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        op_bin,
  input  logic [15:0] diff,
  input  logic        bout,
  output logic        busy,
  output logic        done,
  output logic [5:0]  pass_cnt,
  output logic [5:0]  fail_cnt,
  output logic [15:0] fail_a,
  output logic [15:0] fail_b,
  output logic        fail_bin,
  output logic        fail_valid
);

  // SETTLE-1 cycles in SETTLE: counter runs 0..SETTLE-2
  localparam logic [7:0] SET_LAST = 8'(SETTLE - 2);

  logic [2:0]  state;
  logic [7:0]  scnt;
  logic [5:0]  idx;
  logic [5:0]  n_q;
  logic [15:0] lfsr_a;
  logic [15:0] lfsr_b;
  logic        step;
  logic [16:0] sum;
  logic        ok;

  assign step = (state == ST_CHECK);

  cls_lfsr16 #(.SEED(SEED)) u_lfsr_a (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step),
    .q     (lfsr_a)
  );

  cls_lfsr16 #(.SEED(SEED ^ 16'hFFFF)) u_lfsr_b (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step),
    .q     (lfsr_b)
  );

  // diff + b + bin must rebuild {bout, a}
  assign sum = {1'b0, diff} + {1'b0, op_b}
             + {16'd0, op_bin};
  assign ok  = (sum == {bout, op_a});

  assign busy = (state == ST_LOAD)
             || (state == ST_SETTLE)
             || (state == ST_CHECK);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      scnt       <= '0;
      idx        <= '0;
      n_q        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_bin     <= 1'b0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_bin   <= 1'b0;
      fail_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
            if (num_tests == 6'd0) begin
              state <= ST_DONE;
            end else begin
              fail_valid <= 1'b0;
              idx        <= '0;
              n_q        <= num_tests;
              state      <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (ext_en) begin
            op_a   <= ext_a;
            op_b   <= ext_b;
            op_bin <= ext_bin;
          end else begin
            op_a   <= lfsr_a;
            op_b   <= lfsr_b;
            op_bin <= lfsr_a[0] ^ lfsr_b[0];
          end
          scnt  <= '0;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (scnt == SET_LAST)
            state <= ST_CHECK;
          else
            scnt <= scnt + 8'd1;
        end
        ST_CHECK: begin
          if (ok) begin
            pass_cnt <= pass_cnt + 6'd1;
          end else begin
            fail_cnt <= fail_cnt + 6'd1;
            if (!fail_valid) begin
              fail_a     <= op_a;
              fail_b     <= op_b;
              fail_bin   <= op_bin;
              fail_valid <= 1'b1;
            end
          end
          idx <= idx + 6'd1;
          if (idx + 6'd1 == n_q)
            state <= ST_DONE;
          else
            state <= ST_LOAD;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cls_bist.sv
// Directed bench for cls_bist with a behavioural
// subtractor that can have bout stuck at 0.
module tb_cls_bist;
  import cls_bist_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  num_tests;
  logic        ext_en;
  logic [15:0] ext_a;
  logic [15:0] ext_b;
  logic        ext_bin;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_bin;
  logic [15:0] diff;
  logic        bout;
  logic        busy;
  logic        done;
  logic [5:0]  pass_cnt;
  logic [5:0]  fail_cnt;
  logic [15:0] fail_a;
  logic [15:0] fail_b;
  logic        fail_bin;
  logic        fail_valid;

  logic        stuck0;
  logic [16:0] res;
  int          n_chk = 0;
  int          n_bad = 0;
  logic [15:0] ref_a;

  always #5 clk = ~clk;

  assign res  = {1'b0, op_a} - {1'b0, op_b}
              - {16'd0, op_bin};
  assign diff = res[15:0];
  assign bout = stuck0 ? 1'b0 : res[16];

  cls_bist dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_tests  (num_tests),
    .ext_en     (ext_en),
    .ext_a      (ext_a),
    .ext_b      (ext_b),
    .ext_bin    (ext_bin),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_bin     (op_bin),
    .diff       (diff),
    .bout       (bout),
    .busy       (busy),
    .done       (done),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .fail_a     (fail_a),
    .fail_b     (fail_b),
    .fail_bin   (fail_bin),
    .fail_valid (fail_valid)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [5:0] n);
    num_tests = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic set_ext(input logic [15:0] a,
                         input logic [15:0] b,
                         input logic bi);
    ext_en  = 1'b1;
    ext_a   = a;
    ext_b   = b;
    ext_bin = bi;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    num_tests = '0;
    stuck0    = 1'b0;
    set_ext(16'd0, 16'd0, 1'b0);
    tick(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_pass", 32'(pass_cnt), 32'd0);
    chk("rst_fv", 32'(fail_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // 5 - 3, one vector, 10 cycles incl. start
    set_ext(16'd5, 16'd3, 1'b0);
    do_start(6'd1);
    chk("a_busy", 32'(busy), 32'd1);
    tick(8);
    chk("a_done_early", 32'(done), 32'd0);
    tick();
    chk("a_done", 32'(done), 32'd1);
    chk("a_busy_end", 32'(busy), 32'd0);
    chk("a_pass", 32'(pass_cnt), 32'd1);
    chk("a_fail", 32'(fail_cnt), 32'd0);
    tick(3);
    chk("a_hold", 32'(done), 32'd1);
    chk("a_op_hold", 32'(op_a), 32'd5);

    // 0 - 1 - 1 = 1_FFFE
    set_ext(16'd0, 16'd1, 1'b1);
    do_start(6'd1);
    tick(2);
    chk("b_diff", 32'({bout, diff}), 32'h1FFFE);
    tick(7);
    chk("b_done", 32'(done), 32'd1);
    chk("b_pass", 32'(pass_cnt), 32'd1);
    chk("b_fail", 32'(fail_cnt), 32'd0);

    // bout stuck at 0: 2 - 7 must fail
    stuck0 = 1'b1;
    set_ext(16'd2, 16'd7, 1'b0);
    do_start(6'd1);
    tick(9);
    chk("c_done", 32'(done), 32'd1);
    chk("c_pass", 32'(pass_cnt), 32'd0);
    chk("c_fail", 32'(fail_cnt), 32'd1);
    chk("c_fv", 32'(fail_valid), 32'd1);
    chk("c_fa", 32'(fail_a), 32'd2);
    chk("c_fb", 32'(fail_b), 32'd7);
    chk("c_fbin", 32'(fail_bin), 32'd0);
    stuck0 = 1'b0;

    // LFSR run from the reset seed, 9 vectors
    do_reset();
    ext_en = 1'b0;
    ref_a  = 16'hACE1;
    do_start(6'd9);
    for (int i = 0; i < 9; i++) begin
      tick(2);
      chk($sformatf("d_op_a%0d", i),
          32'(op_a), 32'(ref_a));
      if (i == 0) begin
        chk("d_op_b0", 32'(op_b), 32'h531E);
        chk("d_bin0", 32'(op_bin), 32'd1);
      end
      if (i == 1)
        chk("d_op_a1_hand", 32'(op_a), 32'h59C3);
      ref_a = lfsr_next(ref_a);
      if (i == 8) begin
        tick(6);
        chk("d_done_early", 32'(done), 32'd0);
        tick();
      end else begin
        tick(7);
      end
    end
    chk("d_done", 32'(done), 32'd1);
    chk("d_pass", 32'(pass_cnt), 32'd9);
    chk("d_fail", 32'(fail_cnt), 32'd0);

    // ignored start, then reset mid-run
    set_ext(16'd9, 16'd4, 1'b0);
    do_start(6'd5);
    tick(4);
    num_tests = 6'd0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk("e_busy", 32'(busy), 32'd1);
    chk("e_done", 32'(done), 32'd0);
    tick(16);
    chk("e_pass2", 32'(pass_cnt), 32'd2);
    chk("e_busy3", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("e_rbusy", 32'(busy), 32'd0);
    chk("e_rdone", 32'(done), 32'd0);
    chk("e_rpass", 32'(pass_cnt), 32'd0);
    chk("e_rop", 32'(op_a), 32'd0);
    chk("e_rfv", 32'(fail_valid), 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("e_idle", 32'({busy, done}), 32'd0);

    // num_tests=0: straight to DONE
    do_start(6'd0);
    chk("f_done", 32'(done), 32'd1);
    chk("f_busy", 32'(busy), 32'd0);
    chk("f_pass", 32'(pass_cnt), 32'd0);
    chk("f_fail", 32'(fail_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d",
             n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cls_bist.md
CLS_BIST -- requirements
Module: cls_bist

Interface
REQ-001 Parameter SETTLE, default 8: cycles operands are held stable before the response is sampled (legal 2..255).
REQ-002 Parameter SEED, default 16'hACE1: LFSR-A seed; LFSR-B seed is SEED ^ 16'hFFFF (both nonzero by construction).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
REQ-006 num_tests  input  6  vectors per run, sampled at start.
REQ-007 ext_en  input  1  1 selects ext_a/ext_b/ext_bin as operands instead of the LFSRs; sampled at each LOAD.
REQ-008 ext_a, ext_b  input  16 each; ext_bin  input  1  directed operands.
REQ-009 op_a, op_b  output  16 each; op_bin  output  1  registered operands driven to the 16-bit subtractor under test.
REQ-010 diff  input  16; bout  input  1  subtractor response, with {bout, diff} meaning op_a - op_b - op_bin.
REQ-011 busy  output  1  high in LOAD, SETTLE and CHECK.
REQ-012 done  output  1  high in DONE.
REQ-013 pass_cnt, fail_cnt  output  6 each  vectors judged correct or incorrect in the current run.
REQ-014 fail_a, fail_b  output  16 each; fail_bin  output  1  operands of the first failing vector; fail_valid  output  1.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SETTLE, CHECK and DONE.
REQ-016 IDLE/DONE + start: if num_tests==0, go to DONE with counters cleared; else clear counters, fail_valid and test index, then go to LOAD.
REQ-017 LOAD (1 cycle): register op_* from the ext inputs or the LFSRs, clear the settle counter, go to SETTLE.
REQ-018 LFSR source: op_a=LFSR-A, op_b=LFSR-B, op_bin=LFSR-A[0]^LFSR-B[0].
REQ-019 SETTLE: count cycles; after SETTLE-1 cycles in SETTLE, go to CHECK; op_* stay constant from LOAD through CHECK.
REQ-020 CHECK, inverse-direction check, no subtraction in the checker: compute 17-bit sum {c,s} = diff + op_b + op_bin; the vector passes iff {c,s} == {bout, op_a}.
REQ-021 CHECK on pass: pass_cnt increments.
REQ-022 CHECK on fail: fail_cnt increments; if fail_valid==0, capture op_* into fail_* and set fail_valid.
REQ-023 CHECK exit: advance both LFSRs once (also when ext_en, so sequences stay deterministic), increment the test index, go to DONE if index==num_tests, else to LOAD.
REQ-024 Latency per vector SHALL be exactly SETTLE+1 cycles, LOAD start to CHECK end; a run of N vectors goes from start to DONE in 1+N*(SETTLE+1) cycles.
REQ-025 LFSRs: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0; they are not re-seeded at start, so consecutive runs use fresh vectors.
REQ-026 start outside IDLE/DONE SHALL be ignored, with no effect on state or counters.
REQ-027 Counters SHALL never wrap within a run (num_tests<=63).
REQ-028 DONE: outputs hold until the next accepted start.

Reset
REQ-029 rst_n low: state=IDLE; LFSR-A=SEED and LFSR-B=SEED^16'hFFFF; op_*, counters, fail_*, fail_valid, busy and done all 0.
REQ-030 Reset asserted mid-run SHALL abort immediately; no partial count survives.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the LFSR tap mask and the default SEED.
REQ-032 One sub-module, cls_lfsr16 (parameter SEED; ports clk, rst_n, step, q), SHALL be instantiated twice.
REQ-033 The checker sum SHALL be a single 17-bit add inside cls_bist.

Verification
REQ-034 ext_en=1, a=16'd5, b=16'd3, bin=0, num_tests=1, correct subtractor -> after 10 cycles done=1, pass_cnt=1, fail_cnt=0.
REQ-035 ext_en=1, a=0, b=1, bin=1, correct subtractor (diff=16'hFFFE, bout=1) -> pass_cnt=1.
REQ-036 Subtractor model with bout stuck at 0, ext a=16'd2, b=16'd7, bin=0 -> fail_cnt=1, fail_valid=1, fail_a=2, fail_b=7.
REQ-037 ext_en=0, num_tests=9, correct subtractor -> done after 1+9*9=82 cycles, pass_cnt=9; op_a sequence matches the LFSR-A reference model from 16'hACE1.
REQ-038 rst_n pulsed low in SETTLE of vector 3 -> all outputs 0, state IDLE; start pulses during busy are ignored; num_tests=0 gives done on the next cycle with counts 0.
